// File: rtl/hc_sr04_echo_responder_pkg.sv
// HC-SR04 echo responder: shared state encodings and range constants.
// The range constants are also used by the controller's div-58 path.
package hc_sr04_echo_responder_pkg;

  localparam int US_PER_CM  = 58;
  localparam int MAX_CM     = 400;
  localparam int TIMEOUT_US = 38000;

  localparam int I_IDLE  = 0;
  localparam int I_TRIG  = 1;
  localparam int I_BURST = 2;
  localparam int I_ECHO  = 3;
  localparam int I_GUARD = 4;

  typedef enum logic [4:0] {
    S_IDLE      = 5'b00001,
    S_TRIG_HIGH = 5'b00010,
    S_BURST     = 5'b00100,
    S_ECHO      = 5'b01000,
    S_GUARD     = 5'b10000
  } state_t;

  function automatic logic [15:0] echo_target_us(
    input logic [8:0] d,
    input int         us_per_cm,
    input int         max_cm,
    input int         timeout_us
  );
    logic [15:0] t;
    if (d == 9'd0 || int'(d) > max_cm)
      t = 16'(timeout_us);
    else
      t = 16'(int'(d) * us_per_cm);
    return t;
  endfunction

endpackage

// File: rtl/hc_sr04_echo_responder_if.sv
// Sensor-side signal bundle between an ultrasonic controller
// and the echo responder.
interface hc_sr04_echo_responder_if;

  logic       trig;
  logic [8:0] distance_cm;
  logic       echo;
  logic       busy;
  logic       trig_err;
  logic       done;

  modport master (
    output trig,
    output distance_cm,
    input  echo,
    input  busy,
    input  trig_err,
    input  done
  );

  modport slave (
    input  trig,
    input  distance_cm,
    output echo,
    output busy,
    output trig_err,
    output done
  );

endinterface

// File: rtl/hc_sr04_echo_responder_us_tick_gen.sv
// Microsecond time base: CLK_PER_US prescaler plus a 16-bit us counter,
// both restarted together so measured widths carry no phase error.
module us_tick_gen #(
  parameter int CLK_PER_US = 100
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic        restart,
  output logic        tick,
  output logic [15:0] us_count
);

  localparam int PW =
    (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] PRE_LAST =
    PW'(CLK_PER_US - 1);

  logic [PW-1:0] pre_q;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk) begin
    if (reset_p || restart) begin
      pre_q    <= '0;
      us_count <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + 1'b1;
      if (tick)
        us_count <= us_count + 16'd1;
    end
  end

endmodule

// File: rtl/hc_sr04_echo_responder.sv
// HC-SR04 sensor emulator: validates trig, waits the burst delay, then
// drives echo for a width proportional to the programmed distance.
module hc_sr04_echo_responder #(
  parameter int CLK_PER_US    = 100,
  parameter int US_PER_CM     =
    hc_sr04_echo_responder_pkg::US_PER_CM,
  parameter int TRIG_MIN_US   = 10,
  parameter int ECHO_DELAY_US = 200,
  parameter int MAX_CM        =
    hc_sr04_echo_responder_pkg::MAX_CM,
  parameter int TIMEOUT_US    =
    hc_sr04_echo_responder_pkg::TIMEOUT_US,
  parameter int GUARD_US      = 100
) (
  input logic                     clk,
  input logic                     reset_p,
  hc_sr04_echo_responder_if.slave bus
);

  import hc_sr04_echo_responder_pkg::*;

  localparam int TRIG_MIN_CYC = TRIG_MIN_US * CLK_PER_US;
  localparam logic [10:0] TRIG_SAT = 11'(TRIG_MIN_CYC);
  localparam logic [10:0] TRIG_OK  = 11'(TRIG_MIN_CYC - 1);
  localparam logic [15:0] BURST_LAST = 16'(ECHO_DELAY_US - 1);
  localparam logic [15:0] GUARD_LAST = 16'(GUARD_US - 1);

  logic        trig_m;
  logic        trig_s;
  logic        trig_d;
  logic        trig_rise;
  logic        trig_fall;

  state_t      state_q;
  state_t      state_n;
  logic [10:0] trig_cnt_q;
  logic [8:0]  dist_q;
  logic [15:0] target_q;

  logic        tick;
  logic        restart;
  logic [15:0] us_cnt;
  logic        latch;
  logic        err_n;

  logic        echo_q;
  logic        err_q;
  logic        done_q;

  always_ff @(posedge clk) begin
    if (reset_p) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_m <= bus.trig;
      trig_s <= trig_m;
      trig_d <= trig_s;
    end
  end

  assign trig_rise = trig_s & ~trig_d;
  assign trig_fall = ~trig_s & trig_d;

  us_tick_gen #(
    .CLK_PER_US (CLK_PER_US)
  ) u_tick (
    .clk      (clk),
    .reset_p  (reset_p),
    .restart  (restart),
    .tick     (tick),
    .us_count (us_cnt)
  );

  always_ff @(posedge clk) begin
    if (reset_p)
      state_q <= S_IDLE;
    else
      state_q <= state_n;
  end

  // The rise-detect cycle is spent in IDLE, so a pulse of exactly
  // TRIG_MIN_CYC cycles leaves TRIG_OK counts here.
  always_comb begin
    state_n = state_q;
    latch   = 1'b0;
    err_n   = 1'b0;
    unique case (1'b1)
      state_q[I_IDLE]: begin
        if (trig_rise)
          state_n = S_TRIG_HIGH;
      end
      state_q[I_TRIG]: begin
        if (trig_fall) begin
          if (trig_cnt_q >= TRIG_OK) begin
            state_n = S_BURST;
            latch   = 1'b1;
          end else begin
            state_n = S_IDLE;
            err_n   = 1'b1;
          end
        end
      end
      state_q[I_BURST]: begin
        if (tick && us_cnt == BURST_LAST)
          state_n = S_ECHO;
      end
      state_q[I_ECHO]: begin
        if (tick && us_cnt == target_q - 16'd1)
          state_n = S_GUARD;
      end
      state_q[I_GUARD]: begin
        if (tick && us_cnt == GUARD_LAST)
          state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    restart = (state_n != state_q);
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      trig_cnt_q <= '0;
    end else if (state_q[I_IDLE]) begin
      trig_cnt_q <= '0;
    end else if (state_q[I_TRIG] && trig_s &&
                 trig_cnt_q != TRIG_SAT) begin
      trig_cnt_q <= trig_cnt_q + 11'd1;
    end
  end

  // Target is settled during BURST, long before ECHO consumes it.
  always_ff @(posedge clk) begin
    if (reset_p) begin
      dist_q   <= '0;
      target_q <= '0;
    end else begin
      if (latch)
        dist_q <= bus.distance_cm;
      if (state_q[I_BURST])
        target_q <= echo_target_us(dist_q, US_PER_CM,
                                   MAX_CM, TIMEOUT_US);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      echo_q <= 1'b0;
      err_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      echo_q <= (state_n == S_ECHO);
      err_q  <= err_n;
      done_q <= state_q[I_ECHO] && (state_n == S_GUARD);
    end
  end

  assign bus.echo     = echo_q;
  assign bus.trig_err = err_q;
  assign bus.done     = done_q;
  assign bus.busy     = ~state_q[I_IDLE];

endmodule
